// File: rtl/seq_detect_1011.sv
// Serial 1011 pattern detector with a registered hit pulse and a saturating hit counter.
// Define SEQDET_OVERLAP_EN for overlapping detection (S4 on 0 -> S2); otherwise S4 on 0 -> S0.
module seq_detect_1011 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             RST_N,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr,
   output logic             hit,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] hit_cnt
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      hit_d   = 1'b0;
      cnt_d   = cnt_q;

      if (clr) begin
         state_d = S0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S0: if (din_vld) state_d = din ? S1 : S0;
            S1: if (din_vld) state_d = din ? S1 : S2;
            S2: if (din_vld) state_d = din ? S3 : S0;
            S3: begin
               if (din_vld) begin
                  if (din) begin
                     state_d = S4;
                     hit_d   = 1'b1;
                     cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                  end else begin
                     state_d = S2;
                  end
               end
            end
            S4: begin
               if (din_vld) begin
`ifdef SEQDET_OVERLAP_EN
                  state_d = din ? S1 : S2;
`else
                  state_d = din ? S1 : S0;
`endif
               end
            end
            // Codes 5..7 can only come from an upset; recover regardless of din_vld.
            default: state_d = S0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state   = state_q;
   assign hit     = hit_q;
   assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011; a CNT_W=8 and a CNT_W=2 instance share stimulus.
// Expectations follow SEQDET_OVERLAP_EN the same way the design build does.
module tb_seq_detect_1011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din;
   logic       din_vld;
   logic       clr;
   logic       hit8, hit2;
   logic [2:0] st8, st2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;

   // Stream 1,0,1,1,0,1,1 and hand-derived per-bit results.
   int stream[7] = '{1, 0, 1, 1, 0, 1, 1};
`ifdef SEQDET_OVERLAP_EN
   int exp_st[7]  = '{1, 2, 3, 4, 2, 3, 4};
   int exp_hit[7] = '{0, 0, 0, 1, 0, 0, 1};
   int exp_fcnt   = 2;
`else
   int exp_st[7]  = '{1, 2, 3, 4, 0, 1, 1};
   int exp_hit[7] = '{0, 0, 0, 1, 0, 0, 0};
   int exp_fcnt   = 1;
`endif
   int pat[4] = '{1, 0, 1, 1};

   always #10 clk = ~clk;

   seq_detect_1011 #(.CNT_W(8)) dut8 (
      .clk(clk), .RST_N(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
      .hit(hit8), .state(st8), .hit_cnt(cnt8)
   );

   seq_detect_1011 #(.CNT_W(2)) dut2 (
      .clk(clk), .RST_N(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
      .hit(hit2), .state(st2), .hit_cnt(cnt2)
   );

   // Drive one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic send(input logic d, input logic v, input logic c);
      din     = d;
      din_vld = v;
      clr     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      send(1'b0, 1'b0, 1'b1);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; din = 1'b1; din_vld = 1'b1; clr = 1'b0;
      #1;
      total++;
      if (st8 !== 3'd0 || hit8 !== 1'b0 || cnt8 !== 8'd0) begin
         bad++;
         $display("FAIL reset_async: state=%0d hit=%0b cnt=%0d want 0/0/0", st8, hit8, cnt8);
      end
      #4 rst_n = 1'b1;
      din_vld = 1'b0;
      @(posedge clk); #1;
      total++;
      if (st8 !== 3'd0 || hit8 !== 1'b0 || cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
         bad++;
         $display("FAIL reset_idle: state=%0d hit=%0b cnt8=%0d cnt2=%0d want 0/0/0/0", st8, hit8, cnt8, cnt2);
      end
   endtask

   task automatic test_overlap();
      for (int i = 0; i < 7; i++) begin
         send(stream[i][0], 1'b1, 1'b0);
         total++;
         if (st8 !== exp_st[i][2:0] || hit8 !== exp_hit[i][0]) begin
            bad++;
            $display("FAIL overlap_bit%0d: state=%0d hit=%0b want %0d/%0d", i, st8, hit8, exp_st[i], exp_hit[i]);
         end
      end
      total++;
      if (cnt8 !== exp_fcnt[7:0]) begin
         bad++;
         $display("FAIL overlap_cnt: cnt=%0d want %0d", cnt8, exp_fcnt);
      end
   endtask

   task automatic test_gap();
      do_clear();
      total++;
      if (st8 !== 3'd0 || hit8 !== 1'b0 || cnt8 !== 8'd0) begin
         bad++;
         $display("FAIL gap_clear: state=%0d hit=%0b cnt=%0d want 0/0/0", st8, hit8, cnt8);
      end
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
         total++;
         if (st8 !== 3'd3 || hit8 !== 1'b0) begin
            bad++;
            $display("FAIL gap_hold%0d: state=%0d hit=%0b want 3/0", i, st8, hit8);
         end
      end
      send(1'b1, 1'b1, 1'b0);
      total++;
      if (hit8 !== 1'b1 || cnt8 !== 8'd1 || st8 !== 3'd4) begin
         bad++;
         $display("FAIL gap_hit: hit=%0b cnt=%0d state=%0d want 1/1/4", hit8, cnt8, st8);
      end
      send(1'b1, 1'b0, 1'b0);
      total++;
      if (hit8 !== 1'b0 || cnt8 !== 8'd1 || st8 !== 3'd4) begin
         bad++;
         $display("FAIL gap_pulse_end: hit=%0b cnt=%0d state=%0d want 0/1/4", hit8, cnt8, st8);
      end
   endtask

   task automatic test_back_to_back();
      int nhit;
      nhit = 0;
      do_clear();
      for (int p = 0; p < 5; p++) begin
         for (int j = 0; j < 4; j++) begin
            send(pat[j][0], 1'b1, 1'b0);
            if (hit2 === 1'b1) nhit++;
            total++;
            if (hit2 !== (j == 3)) begin
               bad++;
               $display("FAIL b2b_hit p%0d b%0d: hit=%0b want %0b", p, j, hit2, (j == 3));
            end
         end
         total++;
         if (cnt2 !== ((p < 3) ? 2'(p + 1) : 2'd3)) begin
            bad++;
            $display("FAIL b2b_sat p%0d: cnt=%0d want %0d", p, cnt2, (p < 3) ? p + 1 : 3);
         end
      end
      total++;
      if (nhit != 5 || cnt8 !== 8'd5) begin
         bad++;
         $display("FAIL b2b_total: pulses=%0d cnt8=%0d want 5/5", nhit, cnt8);
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      din_vld = 1'b0;
      total++;
      if (st8 !== 3'd3 || cnt8 !== 8'd0) begin
         bad++;
         $display("FAIL arst_pre: state=%0d cnt=%0d want 3/0", st8, cnt8);
      end
      #12 rst_n = 1'b0;
      #1;
      total++;
      if (st8 !== 3'd0 || hit8 !== 1'b0 || cnt8 !== 8'd0 || st2 !== 3'd0) begin
         bad++;
         $display("FAIL arst_midcycle: state=%0d hit=%0b cnt=%0d want 0/0/0", st8, hit8, cnt8);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) send(pat[j][0], 1'b1, 1'b0);
      total++;
      if (hit8 !== 1'b1 || cnt8 !== 8'd1) begin
         bad++;
         $display("FAIL arst_resume: hit=%0b cnt=%0d want 1/1", hit8, cnt8);
      end
   endtask

   task automatic test_clr_priority();
      do_clear();
      for (int p = 0; p < 5; p++)
         for (int j = 0; j < 4; j++) send(pat[j][0], 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      total++;
      if (cnt8 !== 8'd5 || st8 !== 3'd3) begin
         bad++;
         $display("FAIL clr_pre: cnt=%0d state=%0d want 5/3", cnt8, st8);
      end
      send(1'b1, 1'b1, 1'b1);
      clr = 1'b0;
      total++;
      if (hit8 !== 1'b0 || cnt8 !== 8'd0 || st8 !== 3'd0 || cnt2 !== 2'd0) begin
         bad++;
         $display("FAIL clr_priority: hit=%0b cnt=%0d state=%0d cnt2=%0d want 0/0/0/0", hit8, cnt8, st8, cnt2);
      end
      send(1'b0, 1'b0, 1'b0);
      total++;
      if (hit8 !== 1'b0 || cnt8 !== 8'd0 || st8 !== 3'd0) begin
         bad++;
         $display("FAIL clr_after: hit=%0b cnt=%0d state=%0d want 0/0/0", hit8, cnt8, st8);
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_gap();
      test_back_to_back();
      test_async_reset();
      test_clr_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detect_1011.md
SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the detection counter in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din, input, 1 bit: serial data bit, i.e. the registered Q of the upstream D flip-flop stage.
REQ-005 SHALL have port din_vld, input, 1 bit: din is sampled only when this is high.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of the FSM, hit and counter.
REQ-007 SHALL have port hit, output, 1 bit: registered one-cycle detection pulse.
REQ-008 SHALL have port state, output, 3 bits: current FSM state code.
REQ-009 SHALL have port hit_cnt, output, CNT_W bits: saturating count of detections.

Function
REQ-010 SHALL detect the serial pattern 1,0,1,1, first bit oldest, over valid samples only.
REQ-011 SHALL implement the FSM states and codes S0=0 (none), S1=1 ("1"), S2=2 ("10"), S3=3 ("101") and S4=4 ("1011" matched); codes 5..7 are unreachable and SHALL recover to S0 on the next edge.
REQ-012 SHALL apply these transitions on a valid sample (din=0 / din=1): S0 -> S0 / S1; S1 -> S2 / S1; S2 -> S0 / S3; S3 -> S2 / S4.
REQ-013 SHALL, from S4 on din=1, go to S1; the din=0 transition from S4 is set by REQ-022.
REQ-014 SHALL hold state and drive hit=0 on any edge where din_vld=0.
REQ-015 SHALL register hit=1 for exactly the one cycle following the edge that moves S3 -> S4; hit SHALL be 0 on all other cycles.
REQ-016 SHALL increment hit_cnt on that same edge, so hit and the new hit_cnt value appear together; latency from the accepting bit to hit is 1 clock.
REQ-017 SHALL saturate hit_cnt at 2^CNT_W-1 with no wrap-around; hit still pulses while the counter is saturated.
REQ-018 SHALL, when clr=1 on an edge, force state=S0, hit=0 and hit_cnt=0; clr has priority over din_vld, and a match on the same edge is discarded (no hit, no increment).
REQ-019 SHALL drive the state output directly from the state register, with no combinational path from din to any output.

Reset
REQ-020 SHALL, while RST_N=0, immediately force state=S0, hit=0 and hit_cnt=0, with no clock edge required.
REQ-021 SHALL resume sampling on the first rising clk edge after RST_N rises; reset asserted mid-pattern discards the partial match.

Configuration
REQ-022 SHALL use macro SEQDET_OVERLAP_EN: when defined, S4 on din=0 goes to S2 (overlapping detection); when undefined, S4 on din=0 goes to S0 (non-overlapping, detection restarts).

Verification
REQ-023 SHALL cover: with SEQDET_OVERLAP_EN defined and CNT_W=8, valid stream 1,0,1,1,0,1,1 -> hit pulses after the 4th and 7th bits, final hit_cnt=2.
REQ-024 SHALL cover: with SEQDET_OVERLAP_EN undefined, the same stream -> one hit after the 4th bit, final hit_cnt=1, state=1 at end.
REQ-025 SHALL cover: stream 1,0,1 followed by 3 cycles of din_vld=0 with din toggling, then 1 -> state holds at 3 through the gap, then hit=1 and hit_cnt=1.
REQ-026 SHALL cover: CNT_W=2 and 5 back-to-back 1,0,1,1 patterns -> 5 hit pulses, hit_cnt stops at 3.
REQ-027 SHALL cover: with state=3, drive RST_N=0 at 13 ns into a clock period (between edges) -> state=0, hit=0 and hit_cnt=0 before the next edge; after release, 1,0,1,1 -> hit_cnt=1.
REQ-028 SHALL cover: clr=1 on the same edge as the 4th bit of 1,0,1,1 with hit_cnt=5 -> hit stays 0, hit_cnt=0, state=0.
